fifo_ring: RTL and testbench
============================

FIFO_RING -- requirements
Module: fifo_ring

Interface
REQ-001 Parameter ADDR_WIDTH, default 3: log2 of storage depth; DEPTH = 2**ADDR_WIDTH entries.
REQ-002 Parameter DATA_WIDTH, default 8: entry width in bits; data is signed two's complement.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  synchronous empty command.
REQ-006 in_valid  input  1  producer offers value_in.
REQ-007 in_ready  output  1  block can accept a push.
REQ-008 value_in  input  DATA_WIDTH signed  push data.
REQ-009 out_valid  output  1  head entry present on value_out.
REQ-010 out_ready  input  1  consumer takes head entry.
REQ-011 value_out  output  DATA_WIDTH signed  head entry (first-word fall-through).
REQ-012 reg_select  input  ADDR_WIDTH  peek offset from head (0 = oldest).
REQ-013 peek_out  output  DATA_WIDTH signed  entry at head+reg_select.
REQ-014 peek_valid  output  1  reg_select addresses an occupied entry.
REQ-015 count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-016 full, empty  output  1 each  count==DEPTH, count==0.
REQ-017 overflow  output  1  sticky: push attempted while full.

Function
REQ-018 Storage SHALL be a DEPTH-entry ring addressed by wr_ptr and rd_ptr, each ADDR_WIDTH bits, wrapping modulo DEPTH (DEPTH-1 -> 0).
REQ-019 Push SHALL occur on an edge where in_valid && in_ready: mem[wr_ptr] <= value_in, wr_ptr increments.
REQ-020 in_ready SHALL equal !full, decoded from registered state only (no combinational path from out_ready).
REQ-021 Pop SHALL occur on an edge where out_valid && out_ready: rd_ptr increments; out_valid SHALL equal !empty.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and move both pointers.
REQ-023 count SHALL increment on push-only, decrement on pop-only, hold otherwise; it SHALL never exceed DEPTH nor go below 0.
REQ-024 value_out SHALL be mem[rd_ptr] combinationally when out_valid, else 0.
REQ-025 peek_valid SHALL be (reg_select < count); peek_out SHALL be mem[(rd_ptr+reg_select) mod DEPTH] when peek_valid, else 0; peek is read-only, no state change.
REQ-026 in_valid while full SHALL be dropped (no write, no pointer move) and SHALL set overflow on that edge.
REQ-027 overflow SHALL remain 1 until flush or rst.
REQ-028 flush SHALL, on the next edge, set rd_ptr, wr_ptr, count to 0 and clear overflow; flush SHALL take priority over a same-cycle push or pop (both discarded); memory contents unchanged.
REQ-029 Latency: a pushed value SHALL appear on value_out/peek_out the cycle after its push edge if it is at that position.

Reset
REQ-030 When rst is 1 at an edge: pointers, count, overflow SHALL be 0 and all memory entries SHALL be 0; rst SHALL override flush, push and pop.
REQ-031 Output values after reset: in_ready=1, out_valid=0, empty=1, full=0, count=0, value_out=0, peek_out=0, peek_valid=0, overflow=0.
REQ-032 rst asserted mid-stream SHALL discard all contents in one edge; first push after release lands at address 0.

Verification
REQ-033 Fill: rst, then push 0..7 with out_ready=0 -> count=8, full=1, in_ready=0, value_out=0, peek_out for reg_select=5 is 5.
REQ-034 Overflow: at full push 100 -> no change to contents or count, overflow=1; next cycle overflow still 1.
REQ-035 Drain/wrap: pop 3 (outputs 0,1,2), push -1,-2,-3 -> count=8, value_out=3, reg_select=7 gives -3 (wrapped storage).
REQ-036 Simultaneous: count=4 head=10, push 20 with pop in same cycle -> count=4, value_out next = second entry, new tail reg_select=3 gives 20.
REQ-037 Flush priority: count=5, assert flush with in_valid and out_ready -> count=0, empty=1, overflow=0, peek_valid=0 for all reg_select.
REQ-038 Reset mid-operation: count=6, rst one cycle -> REQ-031 values; push 42 -> value_out=42, count=1.

Source files
------------

// File: rtl/fifo_ring.sv
// rtl/fifo_ring.sv - ring-buffer FIFO with first-word fall-through head, random-access peek and sticky overflow
//
// Purpose:
//   DEPTH = 2**ADDR_WIDTH entry circular queue of signed DATA_WIDTH values.
//   The head entry is presented combinationally on value_out, and any
//   occupied entry can be inspected through peek_out by its offset from the head.
//
// Ports:
//   clk         sole clock, all state changes on the rising edge
//   rst         synchronous active-high reset; clears pointers, count, overflow and storage
//   flush       synchronous empty command; clears pointers, count, overflow (storage kept)
//   in_valid    producer offers value_in
//   in_ready    a push can be accepted (not full)
//   value_in    push data
//   out_valid   head entry present on value_out (not empty)
//   out_ready   consumer takes the head entry
//   value_out   head entry, 0 when empty
//   reg_select  peek offset from the head (0 = oldest)
//   peek_out    entry at head+reg_select, 0 when not occupied
//   peek_valid  reg_select addresses an occupied entry
//   count       occupancy, 0..DEPTH
//   full        count == DEPTH
//   empty       count == 0
//   overflow    sticky flag: a push was offered while full

module fifo_ring #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] value_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] value_out,
  input  logic        [ADDR_WIDTH-1:0] reg_select,
  output logic signed [DATA_WIDTH-1:0] peek_out,
  output logic                         peek_valid,
  output logic        [ADDR_WIDTH:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Occupancy value meaning "every slot holds data".
  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];
  logic        [ADDR_WIDTH-1:0] wr_ptr;
  logic        [ADDR_WIDTH-1:0] rd_ptr;
  logic        [ADDR_WIDTH-1:0] peek_addr;

  logic push;
  logic pop;
  logic drop;

  // Status is decoded only from the registered count, so in_ready never
  // depends combinationally on out_ready: a pop in the same cycle as a push
  // at full does not make room for that push.
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  assign drop = in_valid && full;

  // Pointer arithmetic is ADDR_WIDTH bits wide, so the wrap modulo DEPTH is
  // the natural carry-out truncation.
  assign peek_addr  = rd_ptr + reg_select;
  assign peek_valid = ({1'b0, reg_select} < count);

  assign value_out = out_valid  ? mem[rd_ptr]    : '0;
  assign peek_out  = peek_valid ? mem[peek_addr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      // Any same-cycle push or pop is discarded; storage is left as is.
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= value_in;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      // push only when not full and pop only when not empty, so count
      // stays within 0..DEPTH without explicit saturation.
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_ring.sv
// tb/tb_fifo_ring.sv - self-checking bench for fifo_ring against a queue-based reference model

module tb_fifo_ring;

  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic                 clk;
  logic                 rst;
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] value_in;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] value_out;
  logic        [AW-1:0] reg_select;
  logic signed [DW-1:0] peek_out;
  logic                 peek_valid;
  logic        [AW:0]   count;
  logic                 full;
  logic                 empty;
  logic                 overflow;

  fifo_ring #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .value_in   (value_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .value_out  (value_out),
    .reg_select (reg_select),
    .peek_out   (peek_out),
    .peek_valid (peek_valid),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the queue holds the occupied entries oldest-first.
  int q[$];
  bit m_ovf;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_peek(input int sel);
    return (sel < q.size()) ? q[sel] : 0;
  endfunction

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    check({tag, ".count"},      count,      n);
    check({tag, ".full"},       full,       (n == DEPTH) ? 1 : 0);
    check({tag, ".empty"},      empty,      (n == 0) ? 1 : 0);
    check({tag, ".in_ready"},   in_ready,   (n != DEPTH) ? 1 : 0);
    check({tag, ".out_valid"},  out_valid,  (n != 0) ? 1 : 0);
    check({tag, ".value_out"},  value_out,  (n != 0) ? q[0] : 0);
    check({tag, ".overflow"},   overflow,   m_ovf ? 1 : 0);
    check({tag, ".peek_valid"}, peek_valid, (int'(reg_select) < n) ? 1 : 0);
    check({tag, ".peek_out"},   peek_out,   m_peek(int'(reg_select)));
  endtask

  // Walk every peek offset; each setting is sampled 1 ns later, well before the next edge.
  task automatic sweep(input string tag);
    for (int s = 0; s < DEPTH; s++) begin
      reg_select = AW'(s);
      #1;
      check($sformatf("%s.peek_valid[%0d]", tag, s), peek_valid, (s < q.size()) ? 1 : 0);
      check($sformatf("%s.peek_out[%0d]", tag, s),   peek_out,   m_peek(s));
    end
    reg_select = '0;
  endtask

  // One clock: drive inputs, advance the model by the rules at the edge, sample 1 ns later.
  task automatic cycle(input string tag, input bit iv, input int val, input bit ordy,
                       input bit fl, input bit rs);
    bit was_full, was_empty;
    in_valid  = iv;
    value_in  = DW'(val);
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (rs || fl) begin
      q.delete();
      m_ovf = 0;
    end else begin
      if (iv && was_full) m_ovf = 1;
      if (ordy && !was_empty) void'(q.pop_front());
      if (iv && !was_full) q.push_back(val);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    value_in = '0; reg_select = '0; m_ovf = 0;

    // Reset values
    cycle("reset", 0, 0, 0, 0, 1);
    check("reset.count_zero", count, 0);
    check("reset.in_ready_one", in_ready, 1);
    sweep("reset");

    // Fill 0..7 with no consumer
    for (int i = 0; i < DEPTH; i++) cycle($sformatf("fill%0d", i), 1, i, 0, 0, 0);
    reg_select = 3'd5;
    #1;
    check("fill.peek5", peek_out, 5);
    check("fill.count8", count, 8);
    check("fill.full", full, 1);
    check("fill.value_out", value_out, 0);
    sweep("fill");

    // Overflow at full: dropped push, sticky flag
    cycle("ovf_push", 1, 100, 0, 0, 0);
    check("ovf.flag", overflow, 1);
    cycle("ovf_hold", 0, 0, 0, 0, 0);
    check("ovf.flag_sticky", overflow, 1);
    sweep("ovf");

    // Drain three, then refill with negatives across the wrap
    for (int i = 0; i < 3; i++) begin
      check($sformatf("drain.head%0d", i), value_out, i);
      cycle($sformatf("drain%0d", i), 0, 0, 1, 0, 0);
    end
    for (int i = 1; i <= 3; i++) cycle($sformatf("neg%0d", i), 1, -i, 0, 0, 0);
    reg_select = 3'd7;
    #1;
    check("wrap.count8", count, 8);
    check("wrap.value_out3", value_out, 3);
    check("wrap.peek7", peek_out, -3);
    sweep("wrap");

    // Simultaneous push and pop at count 4
    cycle("sim_flush", 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle($sformatf("sim_fill%0d", i), 1, 10 + i, 0, 0, 0);
    check("sim.head10", value_out, 10);
    cycle("sim_both", 1, 20, 1, 0, 0);
    reg_select = 3'd3;
    #1;
    check("sim.count4", count, 4);
    check("sim.value_out11", value_out, 11);
    check("sim.peek3", peek_out, 20);

    // Flush beats a same-cycle push and pop
    cycle("fp_fill", 1, 21, 0, 0, 0);
    check("fp.count5", count, 5);
    cycle("fp_flush", 1, 55, 1, 1, 0);
    check("fp.count0", count, 0);
    check("fp.empty", empty, 1);
    check("fp.overflow", overflow, 0);
    sweep("fp");

    // Reset mid-stream overrides flush, push and pop
    for (int i = 0; i < 6; i++) cycle($sformatf("mr_fill%0d", i), 1, 30 + i, 0, 0, 0);
    check("mr.count6", count, 6);
    cycle("mr_rst", 1, 77, 1, 1, 1);
    sweep("mr");
    cycle("mr_push42", 1, 42, 0, 0, 0);
    check("mr.value_out42", value_out, 42);
    check("mr.count1", count, 1);

    // Randomized traffic in phases biased toward filling, draining, and balance
    for (int i = 0; i < 600; i++) begin
      int  phase;
      bit  iv, ordy, fl, rs;
      phase = (i / 50) % 3;
      iv   = (phase == 0) ? ($urandom_range(0, 9) < 8) :
             (phase == 1) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 1) == 1);
      ordy = (phase == 0) ? ($urandom_range(0, 9) < 2) :
             (phase == 1) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 1) == 1);
      fl   = ($urandom_range(0, 47) == 0);
      rs   = ($urandom_range(0, 99) == 0);
      reg_select = AW'($urandom_range(0, DEPTH - 1));
      cycle($sformatf("rnd%0d", i), iv, int'($urandom_range(0, 255)) - 128, ordy, fl, rs);
    end
    sweep("rnd_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
